// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: access-size encodings,
// bus widths and the latched request context.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZ_W  = 3;

    localparam logic [SIZ_W-1:0] MEM_BYTE = 3'b000;
    localparam logic [SIZ_W-1:0] MEM_HALF = 3'b001;
    localparam logic [SIZ_W-1:0] MEM_WORD = 3'b010;
    localparam logic [SIZ_W-1:0] MEM_BU   = 3'b100;
    localparam logic [SIZ_W-1:0] MEM_HU   = 3'b101;

    // Context kept for the response phase; address/data live in the ram_* registers.
    typedef struct packed {
        logic             we;
        logic [SIZ_W-1:0] siz;
        logic [1:0]       addr_lo;
    } req_ctx_t;

    // Number of bytes touched by an access; 0 marks an unknown size code.
    function automatic logic [2:0] size_bytes(input logic [SIZ_W-1:0] siz);
        case (siz)
            MEM_BYTE, MEM_BU: return 3'd1;
            MEM_HALF, MEM_HU: return 3'd2;
            MEM_WORD:         return 3'd4;
            default:          return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_extend.sv
// Picks the addressed byte/half out of a RAM word and sign- or zero-extends it.
module mem_extend
    import mem_ctrl_pkg::*;
(
    input  logic [SIZ_W-1:0]  siz,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] result_c
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[{addr, 3'b000} +: 8];
        sel_half = addr[1] ? word[31:16] : word[15:0];
        result_c = word;
        case (siz)
            MEM_BYTE: result_c = {{24{sel_byte[7]}}, sel_byte};
            MEM_BU:   result_c = {24'd0, sel_byte};
            MEM_HALF: result_c = {{16{sel_half[15]}}, sel_half};
            MEM_HU:   result_c = {16'd0, sel_half};
            default:  result_c = word;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store controller between the MEM stage and the byte-addressed data RAM:
// one access at a time, fault checking, RAM handshake and extended load response.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 4096,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [SIZ_W-1:0]  req_siz,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic              ram_start,
    output logic [ADDR_W-1:0] ram_adr,
    output logic              ram_load,
    output logic [DATA_W-1:0] ram_in,
    output logic [SIZ_W-1:0]  ram_siz,
    input  logic [DATA_W-1:0] ram_out,
    input  logic              ram_busy,
    input  logic              ram_done
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state, state_nxt;
    req_ctx_t          ctx, ctx_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;

    logic              req_ready_nxt, resp_valid_nxt, resp_err_nxt, stall_nxt;
    logic [DATA_W-1:0] resp_rdata_nxt;
    logic              ram_start_nxt, ram_load_nxt;
    logic [ADDR_W-1:0] ram_adr_nxt;
    logic [DATA_W-1:0] ram_in_nxt;
    logic [SIZ_W-1:0]  ram_siz_nxt;

    logic [2:0]        nbytes_c;
    logic [ADDR_W:0]   end_addr_c;
    logic              misalign_c, fault_c;
    logic [DATA_W-1:0] load_data_c;

    mem_extend u_extend (
        .siz      (ctx.siz),
        .addr     (ctx.addr_lo),
        .word     (ram_out),
        .result_c (load_data_c)
    );

    // Fault classification of the request currently offered on the port.
    always_comb begin
        nbytes_c   = size_bytes(req_siz);
        end_addr_c = {1'b0, req_addr} + (ADDR_W + 1)'(nbytes_c);
        misalign_c = (((req_siz == MEM_HALF) || (req_siz == MEM_HU)) && req_addr[0])
                   || ((req_siz == MEM_WORD) && (req_addr[1:0] != 2'b00));
        fault_c    = (nbytes_c == 3'd0)
                   || (end_addr_c > (ADDR_W + 1)'(MEM_SIZE))
                   || misalign_c
                   || (req_we && ((req_siz == MEM_BU) || (req_siz == MEM_HU)));
    end

    // Next state and next registered outputs.
    always_comb begin
        state_nxt      = state;
        ctx_nxt        = ctx;
        cnt_nxt        = cnt;
        req_ready_nxt  = 1'b0;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = '0;
        resp_err_nxt   = 1'b0;
        stall_nxt      = 1'b0;
        ram_start_nxt  = 1'b0;
        ram_adr_nxt    = ram_adr;
        ram_load_nxt   = ram_load;
        ram_in_nxt     = ram_in;
        ram_siz_nxt    = ram_siz;

        case (state)
            ST_IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid) begin
                    req_ready_nxt = 1'b0;
                    stall_nxt     = 1'b1;
                    ctx_nxt       = '{we: req_we, siz: req_siz, addr_lo: req_addr[1:0]};
                    if (fault_c) begin
                        state_nxt      = ST_RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt     = ST_ISSUE;
                        ram_start_nxt = 1'b1;
                        ram_load_nxt  = req_we;
                        ram_in_nxt    = req_wdata;
                        ram_adr_nxt   = req_we ? req_addr : {req_addr[ADDR_W-1:2], 2'b00};
                        ram_siz_nxt   = req_we ? req_siz : MEM_WORD;
                    end
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
                stall_nxt = 1'b1;
                cnt_nxt   = '0;
            end
            ST_WAIT: begin
                stall_nxt = 1'b1;
                if (ram_done && !ram_busy) begin
                    state_nxt      = ST_RESP;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = ctx.we ? '0 : load_data_c;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt      = ST_RESP;
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_nxt     = ST_IDLE;
                req_ready_nxt = 1'b1;
            end
            default: begin
                state_nxt     = ST_IDLE;
                req_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ctx        <= '0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            stall      <= 1'b0;
            ram_start  <= 1'b0;
            ram_adr    <= '0;
            ram_load   <= 1'b0;
            ram_in     <= '0;
            ram_siz    <= '0;
        end else begin
            state      <= state_nxt;
            ctx        <= ctx_nxt;
            cnt        <= cnt_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
            stall      <= stall_nxt;
            ram_start  <= ram_start_nxt;
            ram_adr    <= ram_adr_nxt;
            ram_load   <= ram_load_nxt;
            ram_in     <= ram_in_nxt;
            ram_siz    <= ram_siz_nxt;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural RAM with programmable latency,
// byte-array reference model, directed cases then randomized accesses.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int unsigned MEM_SIZE = 4096;
    localparam int unsigned TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_siz = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic        ram_start;
    logic [31:0] ram_adr;
    logic        ram_load;
    logic [31:0] ram_in;
    logic [2:0]  ram_siz;
    logic [31:0] ram_out = '0;
    logic        ram_busy = 1'b0;
    logic        ram_done = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    mem_ctrl #(.MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_siz    (req_siz),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall),
        .ram_start  (ram_start),
        .ram_adr    (ram_adr),
        .ram_load   (ram_load),
        .ram_in     (ram_in),
        .ram_siz    (ram_siz),
        .ram_out    (ram_out),
        .ram_busy   (ram_busy),
        .ram_done   (ram_done)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: acts on the rising edge of ram_start, done drops on that edge.
    logic [7:0] ram_mem [MEM_SIZE];
    logic [7:0] ref_mem [MEM_SIZE];
    logic       ram_init = 1'b0;
    logic       start_d = 1'b0;
    int         lat_cfg = 0;
    bit         hang_cfg = 1'b0;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        start_d <= ram_start;
        if (ram_init) begin
            for (int i = 0; i < int'(MEM_SIZE); i++) ram_mem[i] <= 8'(i * 7 + 3);
        end else if (ram_start && !start_d) begin
            if (!hang_cfg) begin
                if (ram_load) begin
                    ram_mem[ram_adr[11:0]] <= ram_in[7:0];
                    if (ram_siz == MEM_HALF || ram_siz == MEM_WORD)
                        ram_mem[ram_adr[11:0] + 12'd1] <= ram_in[15:8];
                    if (ram_siz == MEM_WORD) begin
                        ram_mem[ram_adr[11:0] + 12'd2] <= ram_in[23:16];
                        ram_mem[ram_adr[11:0] + 12'd3] <= ram_in[31:24];
                    end
                end else begin
                    ram_out <= {ram_mem[ram_adr[11:0] + 12'd3], ram_mem[ram_adr[11:0] + 12'd2],
                                ram_mem[ram_adr[11:0] + 12'd1], ram_mem[ram_adr[11:0]]};
                end
            end
            if (hang_cfg) begin
                ram_done <= 1'b0; ram_busy <= 1'b1; busy_cnt <= 0;
            end else if (lat_cfg == 0) begin
                ram_done <= 1'b1; ram_busy <= 1'b0; busy_cnt <= 0;
            end else begin
                ram_done <= 1'b0; ram_busy <= 1'b1; busy_cnt <= lat_cfg;
            end
        end else if (busy_cnt > 0) begin
            if (busy_cnt == 1) begin
                ram_done <= 1'b1; ram_busy <= 1'b0;
            end
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access through the port; expected outcome derived from the byte-array model.
    task automatic txn(input bit we, input logic [2:0] siz, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input bit hang,
                       output logic [31:0] rdata, output bit err, output int lat_got);
        int          n, k, starts, stall_bad, hold_bad, idle_bad, exp_lat;
        bit          fault, exp_err;
        logic [31:0] v, exp_rdata, cap_adr, cap_in;
        logic [2:0]  cap_siz;
        logic        cap_load;

        n = (siz == MEM_WORD) ? 4 : ((siz == MEM_HALF || siz == MEM_HU) ? 2 : 1);
        fault = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00)
              || (({32'd0, addr} + 64'(n)) > 64'(MEM_SIZE))
              || (we && (siz == MEM_BU || siz == MEM_HU));
        exp_err = fault || hang;
        exp_lat = fault ? 1 : (hang ? 2 + int'(TIMEOUT) : 3 + lat);
        v = '0;
        if (!fault) begin
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + 32'(i)]) << (8 * i));
            if (siz == MEM_BYTE && v[7])  v = v | 32'hFFFF_FF00;
            if (siz == MEM_HALF && v[15]) v = v | 32'hFFFF_0000;
        end
        exp_rdata = (exp_err || we) ? 32'd0 : v;
        if (we && !exp_err)
            for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8 * i +: 8];

        lat_cfg  = lat;
        hang_cfg = hang;
        check("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_siz = siz; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;

        k = 1; lat_got = -1; starts = 0; stall_bad = 0; hold_bad = 0; idle_bad = 0;
        rdata = 32'hxxxx_xxxx; err = 1'bx;
        cap_adr = '0; cap_in = '0; cap_siz = '0; cap_load = 1'b0;
        while (k <= 60) begin
            if (ram_start) begin
                starts++;
                cap_adr = ram_adr; cap_in = ram_in; cap_siz = ram_siz; cap_load = ram_load;
            end else if (starts > 0 && !resp_valid &&
                         (ram_adr !== cap_adr || ram_in !== cap_in ||
                          ram_siz !== cap_siz || ram_load !== cap_load)) begin
                hold_bad++;
            end
            if (stall !== 1'b1) stall_bad++;
            if (!resp_valid && (resp_rdata !== 32'd0 || resp_err !== 1'b0)) idle_bad++;
            if (resp_valid) begin
                lat_got = k; rdata = resp_rdata; err = resp_err;
                break;
            end
            @(posedge clk); #1;
            k++;
        end

        check("latency", 32'(lat_got), 32'(exp_lat));
        check("resp_err", 32'(err), 32'(exp_err));
        check("resp_rdata", rdata, exp_rdata);
        check("ram_starts", 32'(starts), fault ? 32'd0 : 32'd1);
        check("stall_during", 32'(stall_bad), 32'd0);
        check("ram_hold", 32'(hold_bad), 32'd0);
        check("resp_quiet", 32'(idle_bad), 32'd0);
        if (!fault) begin
            check("ram_adr", cap_adr, we ? addr : {addr[31:2], 2'b00});
            check("ram_siz", 32'(cap_siz), 32'(we ? siz : MEM_WORD));
            check("ram_load", 32'(cap_load), 32'(we));
            if (we) check("ram_in", cap_in, wdata);
        end

        @(posedge clk); #1;
        check("stall_after", 32'(stall), 32'd0);
        check("resp_after", 32'(resp_valid), 32'd0);
        check("ready_after", 32'(req_ready), 32'd1);
    endtask

    logic [2:0]  siz_tab [5];
    logic [31:0] rd;
    bit          er;
    int          lg;

    initial begin
        int quiet_bad;
        logic [31:0] a;
        siz_tab[0] = MEM_BYTE; siz_tab[1] = MEM_HALF; siz_tab[2] = MEM_WORD;
        siz_tab[3] = MEM_BU;   siz_tab[4] = MEM_HU;
        for (int i = 0; i < int'(MEM_SIZE); i++) ref_mem[i] = 8'(i * 7 + 3);

        rst = 1'b1; ram_init = 1'b1;
        @(posedge clk); #1;
        ram_init = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ram_start", 32'(ram_start), 32'd0);
        check("rst_ram_adr", ram_adr, 32'd0);
        rst = 1'b0;

        txn(1'b1, MEM_WORD, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, rd, er, lg);
        check("st_word_err", 32'(er), 32'd0);
        txn(1'b0, MEM_WORD, 32'h10, 32'd0, 0, 1'b0, rd, er, lg);
        check("ld_word_data", rd, 32'hDEAD_BEEF);
        check("ld_word_lat", 32'(lg), 32'd3);
        txn(1'b0, MEM_BYTE, 32'h13, 32'd0, 1, 1'b0, rd, er, lg);
        check("ld_byte_sext", rd, 32'hFFFF_FFDE);
        txn(1'b0, MEM_BU, 32'h13, 32'd0, 0, 1'b0, rd, er, lg);
        check("ld_bu_zext", rd, 32'h0000_00DE);
        txn(1'b0, MEM_HU, 32'h12, 32'd0, 2, 1'b0, rd, er, lg);
        check("ld_hu_zext", rd, 32'h0000_DEAD);
        txn(1'b0, MEM_HALF, 32'h11, 32'd0, 0, 1'b0, rd, er, lg);
        check("misalign_err", 32'(er), 32'd1);
        check("misalign_lat", 32'(lg), 32'd1);
        txn(1'b0, MEM_WORD, 32'hFFC, 32'd0, 0, 1'b0, rd, er, lg);
        check("top_word_ok", 32'(er), 32'd0);
        txn(1'b0, MEM_WORD, 32'h1000, 32'd0, 0, 1'b0, rd, er, lg);
        check("range_err", 32'(er), 32'd1);
        txn(1'b1, MEM_BU, 32'h20, 32'h55, 0, 1'b0, rd, er, lg);
        check("store_bu_err", 32'(er), 32'd1);
        txn(1'b0, MEM_WORD, 32'h20, 32'd0, 0, 1'b1, rd, er, lg);
        check("timeout_err", 32'(er), 32'd1);
        check("timeout_lat", 32'(lg), 32'(2 + int'(TIMEOUT)));

        // Reset while the RAM access is outstanding.
        hang_cfg = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_siz = MEM_WORD; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", 32'(req_ready), 32'd1);
        check("midrst_start", 32'(ram_start), 32'd0);
        check("midrst_resp", 32'(resp_valid), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        quiet_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) quiet_bad++;
        end
        check("midrst_no_resp", 32'(quiet_bad), 32'd0);
        txn(1'b0, MEM_WORD, 32'h10, 32'd0, 0, 1'b0, rd, er, lg);
        check("after_rst_load", rd, 32'hDEAD_BEEF);

        for (int t = 0; t < 200; t++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 14)       a = 32'h10 + $urandom_range(0, 47);
            else if (r < 18)  a = 32'hFF0 + $urandom_range(0, 15);
            else if (r == 18) a = 32'h1000 + $urandom_range(0, 3);
            else              a = 32'hFFFF_FFFC + $urandom_range(0, 3);
            txn(1'($urandom_range(0, 1)), siz_tab[$urandom_range(0, 4)], a, $urandom,
                int'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0), rd, er, lg);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
